sram_controller: RTL and testbench

- Off-chip SRAM controller sitting directly downstream of the MEM stage; replaces the on-chip data memory.
- Accepts one 32-bit word read or write per request and performs it as two sequential 16-bit SRAM accesses.
- Holds `ready` low while busy so the pipeline freezes all stage registers until the access completes.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_controller.sv | 112 +++++++++++
 tb/tb_sram_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM encoding, half-word select constants and default base address
// for the off-chip SRAM controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: performs one 32-bit pipeline load/store as two 16-bit SRAM accesses,
// holding ready low so the pipeline freezes until the access completes.
//   clk, rst (sync, active-low)
//   wr_en, rd_en, address, writeData : request from the MEM stage (write wins if both)
//   readData, ready                   : load result and pipeline freeze control
//   SRAM_*                            : half-word SRAM pins; pad tri-state built from
//                                       SRAM_DQ_out/SRAM_DQ_oe outside this block
// Optional: define SRAM_STATS_EN to add saturating rd_count/wr_count outputs.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
`ifdef SRAM_STATS_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);

    state_t             state, state_nxt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wdata;
    logic [31:0]        rbuf;
    logic [3:0]         cnt;
    logic               req;
    logic               act;
    logic               half;
    logic               enter_done;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    always_comb begin
        req        = wr_en | rd_en;
        act        = (state == LO) || (state == HI);
        half       = (state == HI) ? HALF_HI : HALF_LO;
        state_nxt  = (state == IDLE) ? (req ? LO : IDLE) :
                     (state == LO)   ? HI :
                     (state == HI)   ? ((WAIT_CYCLES == 0) ? DONE : WAIT) :
                     (state == WAIT) ? ((cnt == 4'(WAIT_CYCLES - 1)) ? DONE : WAIT) :
                                       IDLE;
        enter_done = (state_nxt == DONE);
        // Gated by rst so no completion is ever signalled while held in reset.
        ready       = rst && (((state == IDLE) && !req) || (state == DONE));
        SRAM_ADDR   = act ? {word, half} : '0;
        SRAM_CE_N   = !act;
        SRAM_WE_N   = !(act && op_wr);
        SRAM_OE_N   = !(act && !op_wr);
        SRAM_DQ_oe  = act && op_wr;
        SRAM_DQ_out = (act && op_wr) ? (half ? wdata[31:16] : wdata[15:0]) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            word     <= '0;
            wdata    <= '0;
            rbuf     <= '0;
            cnt      <= '0;
            readData <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
            if ((state == IDLE) && req) begin
                op_wr <= wr_en;
                // Truncation to the SRAM word width makes out-of-range addresses wrap.
                word  <= (SRAM_AW - 1)'((address - BASE_ADDR) >> 2);
                wdata <= writeData;
            end
            if (act && !op_wr)
                rbuf <= half ? {SRAM_DQ_in, rbuf[15:0]} : {rbuf[31:16], SRAM_DQ_in};
            // With no wait cycles DONE follows HI directly, so take the high half from the pad.
            if (enter_done && !op_wr)
                readData <= (state == HI) ? {SRAM_DQ_in, rbuf[15:0]} : rbuf;
        end
    end

`ifdef SRAM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_count <= (enter_done && !op_wr && rd_count != 16'hFFFF) ? rd_count + 16'd1 : rd_count;
            wr_count <= (enter_done && op_wr && wr_count != 16'hFFFF) ? wr_count + 16'd1 : wr_count;
        end
    end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed and randomized checks of sram_controller against a
// word-level memory model and a simple half-word SRAM device.
module tb_sram_controller;

    localparam int W   = 2;
    localparam int LAT = 3 + W;
    localparam int AW  = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [31:0]   address = '0;
    logic [31:0]   writeData = '0;
    logic [31:0]   readData;
    logic          ready;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_DQ_out;
    logic          SRAM_DQ_oe;
    logic [15:0]   SRAM_DQ_in;
    logic          SRAM_WE_N;
    logic          SRAM_OE_N;
    logic          SRAM_CE_N;
    logic          SRAM_UB_N;
    logic          SRAM_LB_N;
`ifdef SRAM_STATS_EN
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
    int            n_rd = 0;
    int            n_wr = 0;
`endif

    int total = 0;
    int bad   = 0;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData), .readData(readData), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
`ifdef SRAM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    bit [15:0] mem [0:(1<<AW)-1];
    always @(posedge clk)
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ_out;
    assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR] : 16'h0;

    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd = '0;

    logic [AW-1:0] t_addr [0:40];
    logic [15:0]   t_dq   [0:40];
    logic          t_we   [0:40];
    logic          t_oe   [0:40];
    logic          t_dqoe [0:40];
    logic          t_rdy0;

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] ref_read(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; writeData = d;
        #1 t_rdy0 = ready;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            t_addr[c] = SRAM_ADDR;
            t_dq[c]   = SRAM_DQ_out;
            t_we[c]   = SRAM_WE_N;
            t_oe[c]   = SRAM_OE_N;
            t_dqoe[c] = SRAM_DQ_oe;
            if (ready) begin
                lat = c;
                break;
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic txn(input string tag, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
        int lat;
        int wd;
        wd = word_of(a);
        if (w) ref_mem[wd] = d;
        else exp_rd = ref_read(wd);
        access(w, r, a, d, lat);
        check($sformatf("%s.ready0", tag), {31'b0, t_rdy0}, 32'd0);
        check($sformatf("%s.latency", tag), 32'(lat), 32'(LAT));
        check($sformatf("%s.readData", tag), readData, exp_rd);
        check($sformatf("%s.addr_lo", tag), 32'(t_addr[1]), 32'(wd * 2));
        check($sformatf("%s.addr_hi", tag), 32'(t_addr[2]), 32'(wd * 2 + 1));
        check($sformatf("%s.dq_oe", tag), {30'b0, t_dqoe[1], t_dqoe[2]}, w ? 32'd3 : 32'd0);
`ifdef SRAM_STATS_EN
        if (w) n_wr++; else n_rd++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wd;
        int op;
        int mode;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        check("rst.ready", {31'b0, ready}, 32'd0);
        check("rst.ce_n", {31'b0, SRAM_CE_N}, 32'd1);
        check("rst.we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("rst.oe_n", {31'b0, SRAM_OE_N}, 32'd1);
        check("rst.dq_oe", {31'b0, SRAM_DQ_oe}, 32'd0);
        check("rst.addr", 32'(SRAM_ADDR), 32'd0);
        check("rst.dq_out", 32'(SRAM_DQ_out), 32'd0);
        check("rst.readData", readData, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.ready", {31'b0, ready}, 32'd1);
        check("idle.ce_n", {31'b0, SRAM_CE_N}, 32'd1);

        txn("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        check("wr1024.a1", 32'(t_addr[1]), 32'd0);
        check("wr1024.a2", 32'(t_addr[2]), 32'd1);
        check("wr1024.dq1", 32'(t_dq[1]), 32'h0000BEEF);
        check("wr1024.dq2", 32'(t_dq[2]), 32'h0000DEAD);
        check("wr1024.we", {30'b0, t_we[1], t_we[2]}, 32'd0);

        txn("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0);
        check("rd1024.data", readData, 32'hDEADBEEF);
        check("rd1024.oe", {30'b0, t_oe[1], t_oe[2]}, 32'd0);

        txn("both1028", 1'b1, 1'b1, 32'd1028, 32'h12345678);
        check("both1028.a1", 32'(t_addr[1]), 32'd2);
        check("both1028.a2", 32'(t_addr[2]), 32'd3);
        check("both1028.we", {30'b0, t_we[1], t_we[2]}, 32'd0);
        check("both1028.keep", readData, 32'hDEADBEEF);

        txn("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0);
        check("rd1032.a1", 32'(t_addr[1]), 32'd4);
        check("rd1032.a2", 32'(t_addr[2]), 32'd5);
        txn("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0);
        check("rd1028.data", readData, 32'h12345678);

        @(negedge clk);
        wr_en = 1'b1; address = 32'd1036; writeData = 32'hAAAA5555;
        @(negedge clk);
        check("abort.we_lo", {31'b0, SRAM_WE_N}, 32'd0);
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("abort.we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("abort.ce_n", {31'b0, SRAM_CE_N}, 32'd1);
        check("abort.ready", {31'b0, ready}, 32'd0);
        check("abort.readData", readData, 32'd0);
        @(negedge clk);
        check("abort.ready2", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        exp_rd = 32'd0;
`ifdef SRAM_STATS_EN
        n_rd = 0; n_wr = 0;
`endif
        @(negedge clk);
        check("abort.release", {31'b0, ready}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            op   = int'($urandom_range(0, 2));
            wd   = int'($urandom_range(8, 23));
            mode = int'($urandom_range(0, 3));
            a = 32'd1024 + 32'(wd * 4) + $urandom_range(0, 3);
            if (mode == 1) a = a + 32'h80000;
            if (mode == 2) a = a - 32'h80000;
            txn($sformatf("rnd%0d", i), op != 1, op != 0, a, $urandom);
        end

        repeat (3) @(negedge clk);
        check("end.ready", {31'b0, ready}, 32'd1);
        check("end.ce_n", {31'b0, SRAM_CE_N}, 32'd1);
`ifdef SRAM_STATS_EN
        check("stats.wr", 32'(wr_count), 32'(n_wr));
        check("stats.rd", 32'(rd_count), 32'(n_rd));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
